// File: rtl/apb4_regbank_pkg.sv
// Shared definitions for the APB4 slave register bank.
//   state_t        : transfer FSM states (IDLE -> optional WAIT -> RESP).
//   CFG_IDX        : word index of the CFG register (wait-count field).
//   STATUS_IDX     : word index of the read-only STATUS register (ERRCNT).
//   ERRCNT_W       : width of the saturating error counter.
package apb4_regbank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int CFG_IDX    = 0;
  localparam int STATUS_IDX = 1;
  localparam int ERRCNT_W   = 8;

endpackage

// File: rtl/apb_wait_timer.sv
// Down-counter that times the wait states of one APB transfer.
// Ports:
//   clk, rst   : clock and synchronous active-high reset (count -> 0).
//   load       : load count with value (takes priority over decrement).
//   value      : count to load.
//   decrement  : count down by one; holds at zero.
//   done       : high while count equals 1, i.e. the last wait cycle.
module apb_wait_timer
  import apb4_regbank_pkg::*;
#(
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] value,
  input  logic              decrement,
  output logic              done
);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (decrement && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == WAIT_W'(1));

endmodule

// File: rtl/apb4_slave_regbank.sv
// APB4 slave exposing a small register bank with programmable wait states.
// Register map (word index): 0 CFG (WAIT field, r/w), 1 STATUS (ERRCNT, r/o),
// 2..NUM_REGS-1 data registers (r/w, byte strobes honoured).
// Ports:
//   PCLK, PRESET           : clock, synchronous active-high reset.
//   PSEL, PENABLE, PWRITE  : APB control.
//   PADDR, PWDATA, PSTRB   : byte address, write data, write byte strobes.
//   PRDATA                 : read data, held until the next read response.
//   PREADY, PSLVERR        : one-cycle completion pulse and error flag.
// Handshake: a transfer starts when PSEL&&PENABLE is seen in IDLE; PREADY is
// high for exactly one cycle (RESP), CFG.WAIT+1 cycles after the first access
// cycle. Dropping PSEL during WAIT abandons the transfer silently.
module apb4_slave_regbank
  import apb4_regbank_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 8,
  parameter int NUM_REGS     = 8,
  parameter int WAIT_W       = 4,
  parameter int WAIT_DEFAULT = 2
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int NBYTES = DATA_W / 8;
  localparam int OFF_W  = $clog2(NBYTES);

  localparam logic [ADDR_W-1:0] OFF_MASK   = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] CFG_A      = ADDR_W'(CFG_IDX);
  localparam logic [ADDR_W-1:0] STATUS_A   = ADDR_W'(STATUS_IDX);

  state_t              state;
  logic [WAIT_W-1:0]   cfg_wait;
  logic [ERRCNT_W-1:0] errcnt;
  logic [DATA_W-1:0]   data_regs [NUM_REGS-2];

  logic [ADDR_W-1:0] idx;
  logic              addr_bad;
  logic              xfer_err;
  logic              access;
  logic              enter_resp;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] wr_val;

  logic              timer_load;
  logic [WAIT_W-1:0] timer_value;
  logic              timer_dec;
  logic              timer_done;

  assign idx      = PADDR >> OFF_W;
  assign addr_bad = (idx >= NUM_REGS_A) || ((PADDR & OFF_MASK) != '0);
  assign xfer_err = addr_bad || (PWRITE && (idx == STATUS_A));
  assign access   = PSEL && PENABLE;

  // The response is formed at the edge that enters RESP so that PREADY,
  // PSLVERR and PRDATA are all registered and appear together. The address
  // phase signals are stable from the access phase through RESP, so this is
  // the same data the master presents while PREADY is high.
  assign enter_resp = ((state == ST_IDLE) && access && (cfg_wait == '0)) ||
                      ((state == ST_WAIT) && PSEL && timer_done);

  // An abort reloads the timer with zero so it is idle for the next transfer.
  assign timer_load  = ((state == ST_IDLE) && access) ||
                       ((state == ST_WAIT) && !PSEL);
  assign timer_value = (state == ST_IDLE) ? cfg_wait : '0;
  assign timer_dec   = (state == ST_WAIT) && PSEL;

  apb_wait_timer #(
    .WAIT_W(WAIT_W)
  ) u_wait_timer (
    .clk       (PCLK),
    .rst       (PRESET),
    .load      (timer_load),
    .value     (timer_value),
    .decrement (timer_dec),
    .done      (timer_done)
  );

  // Current value of the addressed register (0 for unmapped indices).
  always_comb begin
    rd_val = '0;
    if (idx == CFG_A) begin
      rd_val = DATA_W'(cfg_wait);
    end else if (idx == STATUS_A) begin
      rd_val = DATA_W'(errcnt);
    end else begin
      for (int i = 2; i < NUM_REGS; i++) begin
        if (idx == ADDR_W'(i)) rd_val = data_regs[i-2];
      end
    end
  end

  // Strobed merge: lanes without a strobe keep the current register value.
  always_comb begin
    wr_val = rd_val;
    for (int b = 0; b < NBYTES; b++) begin
      if (PSTRB[b]) wr_val[b*8 +: 8] = PWDATA[b*8 +: 8];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= ST_IDLE;
      PREADY   <= 1'b0;
      PSLVERR  <= 1'b0;
      PRDATA   <= '0;
      cfg_wait <= WAIT_W'(WAIT_DEFAULT);
      errcnt   <= '0;
      for (int i = 0; i < NUM_REGS - 2; i++) data_regs[i] <= '0;
    end else begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;

      case (state)
        ST_IDLE: if (access) state <= (cfg_wait == '0) ? ST_RESP : ST_WAIT;
        ST_WAIT: begin
          if (!PSEL)           state <= ST_IDLE;
          else if (timer_done) state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (enter_resp) begin
        PREADY  <= 1'b1;
        PSLVERR <= xfer_err;
        // STATUS reads see the count before this response's own increment.
        if (!PWRITE) PRDATA <= xfer_err ? '0 : rd_val;
        if (xfer_err) begin
          if (errcnt != '1) errcnt <= errcnt + 1'b1;
        end else if (PWRITE) begin
          if (idx == CFG_A) cfg_wait <= wr_val[WAIT_W-1:0];
          for (int i = 2; i < NUM_REGS; i++) begin
            if (idx == ADDR_W'(i)) data_regs[i-2] <= wr_val;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb4_slave_regbank.sv
// Self-checking bench for apb4_slave_regbank at default parameters.
module tb_apb4_slave_regbank;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  apb4_slave_regbank dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  // ---------------- clock / watchdog ----------------
  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  logic        exp_is_rd_q[$];
  int          exp_lat_q[$];
  logic [31:0] model [8];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic apb_xfer(input string tag, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
    int          lat;
    logic        seen;
    logic [31:0] e_rd;
    logic        e_err;
    logic        e_is_rd;
    int          e_lat;
    exp_q.push_back(exp_rd);
    exp_err_q.push_back(exp_err);
    exp_is_rd_q.push_back(!wr);
    exp_lat_q.push_back(exp_lat);

    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
    @(negedge PCLK);
    PENABLE = 1'b1;

    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 40) begin
      @(posedge PCLK);
      #1;
      lat++;
      if (PREADY) seen = 1'b1;
    end

    e_rd    = exp_q.pop_front();
    e_err   = exp_err_q.pop_front();
    e_is_rd = exp_is_rd_q.pop_front();
    e_lat   = exp_lat_q.pop_front();

    if (!seen) begin
      check_val({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check_val({tag, "_lat"}, 32'(lat), 32'(e_lat));
      check_val({tag, "_err"}, 32'(PSLVERR), 32'(e_err));
      if (e_is_rd) check_val({tag, "_rdata"}, PRDATA, e_rd);
    end

    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 4'h0;
    @(posedge PCLK);
    #1;
    check_val({tag, "_pulse"}, 32'(PREADY), 32'd0);
  endtask

  // Starts a transfer and leaves it in WAIT after the first access cycle.
  task automatic start_into_wait(input logic wr, input logic [7:0] addr, input logic [31:0] wdata);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = 4'hF;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(posedge PCLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        seen;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    int          k;

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    for (int i = 0; i < 8; i++) model[i] = '0;

    repeat (3) @(posedge PCLK);
    #1;
    check_val("rst_pready", 32'(PREADY), 32'd0);
    check_val("rst_pslverr", 32'(PSLVERR), 32'd0);
    check_val("rst_prdata", PRDATA, 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(posedge PCLK);
    #1;
    check_val("post_rst_no_pready", 32'(PREADY), 32'd0);

    // Basic write/read with default 2 wait states.
    apb_xfer("wr08", 1, 8'h08, 32'h11223344, 4'hF, 0, 32'h0, 3);
    apb_xfer("rd08", 0, 8'h08, 32'h0, 4'h0, 0, 32'h11223344, 3);
    apb_xfer("wr08_strb", 1, 8'h08, 32'hAABBCCDD, 4'b0101, 0, 32'h0, 3);
    apb_xfer("rd08_strb", 0, 8'h08, 32'h0, 4'h0, 0, 32'h11BB33DD, 3);
    model[2] = 32'h11BB33DD;

    // Wait-count changes apply from the next transfer.
    apb_xfer("wr_cfg0", 1, 8'h00, 32'h0, 4'hF, 0, 32'h0, 3);
    apb_xfer("rd08_w0", 0, 8'h08, 32'h0, 4'h0, 0, 32'h11BB33DD, 1);
    apb_xfer("wr_cfg5", 1, 8'h00, 32'h5, 4'hF, 0, 32'h0, 1);
    apb_xfer("rd_cfg5", 0, 8'h00, 32'h0, 4'h0, 0, 32'h5, 6);
    apb_xfer("wr_cfg1", 1, 8'h00, 32'h1, 4'hF, 0, 32'h0, 6);

    // Random strobed writes against the bench model, then read back.
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(2, 7);
      a = 8'(k * 4);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      model[k] = merge(model[k], d, s);
      apb_xfer($sformatf("rnd_wr%0d", i), 1, a, d, s, 0, 32'h0, 2);
    end
    for (int i = 2; i < 8; i++) begin
      apb_xfer($sformatf("rnd_rd%0d", i), 0, 8'(i * 4), 32'h0, 4'h0, 0, model[i], 2);
    end
    apb_xfer("wr_nostrb", 1, 8'h0C, 32'hDEADBEEF, 4'h0, 0, 32'h0, 2);
    apb_xfer("rd_nostrb", 0, 8'h0C, 32'h0, 4'h0, 0, model[3], 2);

    // CFG keeps only the WAIT field; upper bits read 0.
    apb_xfer("wr_cfg_hi", 1, 8'h00, 32'hFFFFFFF0, 4'hF, 0, 32'h0, 2);
    apb_xfer("rd_cfg_hi", 0, 8'h00, 32'h0, 4'h0, 0, 32'h0, 1);

    // Error responses and ERRCNT.
    apb_xfer("wr_status", 1, 8'h04, 32'h55, 4'hF, 1, 32'h0, 1);
    apb_xfer("rd_status1", 0, 8'h04, 32'h0, 4'h0, 0, 32'h1, 1);
    apb_xfer("rd_oor", 0, 8'h20, 32'h0, 4'h0, 1, 32'h0, 1);
    apb_xfer("rd_misal", 0, 8'h09, 32'h0, 4'h0, 1, 32'h0, 1);
    apb_xfer("rd_status3", 0, 8'h04, 32'h0, 4'h0, 0, 32'h3, 1);
    apb_xfer("wr_misal", 1, 8'h0A, 32'h12345678, 4'hF, 1, 32'h0, 1);
    apb_xfer("rd_after_bad_wr", 0, 8'h08, 32'h0, 4'h0, 0, model[2], 1);
    apb_xfer("rd_status4", 0, 8'h04, 32'h0, 4'h0, 0, 32'h4, 1);

    // Saturation.
    for (int i = 0; i < 260; i++) apb_xfer("sat_err", 0, 8'h20, 32'h0, 4'h0, 1, 32'h0, 1);
    apb_xfer("rd_status_sat", 0, 8'h04, 32'h0, 4'h0, 0, 32'hFF, 1);

    // Abort in WAIT.
    apb_xfer("wr_cfg3", 1, 8'h00, 32'h3, 4'hF, 0, 32'h0, 1);
    apb_xfer("wr0c_full", 1, 8'h0C, 32'hCAFE0001, 4'hF, 0, 32'h0, 4);
    model[3] = 32'hCAFE0001;
    start_into_wait(1, 8'h0C, 32'h0BAD0BAD);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge PCLK);
      #1;
      if (PREADY) seen = 1'b1;
    end
    check_val("abort_no_pready", 32'(seen), 32'd0);
    apb_xfer("rd0c_after_abort", 0, 8'h0C, 32'h0, 4'h0, 0, 32'hCAFE0001, 4);
    apb_xfer("rd_status_abort", 0, 8'h04, 32'h0, 4'h0, 0, 32'hFF, 4);
    apb_xfer("rd0c_nonzero", 0, 8'h0C, 32'h0, 4'h0, 0, 32'hCAFE0001, 4);

    // Reset in WAIT.
    start_into_wait(0, 8'h10, 32'h0);
    @(negedge PCLK);
    PRESET = 1'b1;
    @(posedge PCLK);
    #1;
    check_val("midrst_pready", 32'(PREADY), 32'd0);
    check_val("midrst_pslverr", 32'(PSLVERR), 32'd0);
    check_val("midrst_prdata", PRDATA, 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK);
    #1;
    check_val("midrst_post_pready", 32'(PREADY), 32'd0);
    apb_xfer("rd_cfg_rst", 0, 8'h00, 32'h0, 4'h0, 0, 32'h2, 3);
    apb_xfer("rd08_rst", 0, 8'h08, 32'h0, 4'h0, 0, 32'h0, 3);
    apb_xfer("rd0c_rst", 0, 8'h0C, 32'h0, 4'h0, 0, 32'h0, 3);
    apb_xfer("rd1c_rst", 0, 8'h1C, 32'h0, 4'h0, 0, 32'h0, 3);
    apb_xfer("rd_status_rst", 0, 8'h04, 32'h0, 4'h0, 0, 32'h0, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
